// File: rtl/fdiv_pkg.sv
// rtl/fdiv_pkg.sv - shared binary32 field widths, constants and FIFO entry type for the divider output stage
package fdiv_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int WORD_W = SIGN_W + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0]  EXP_MAX  = 8'hFF;
  localparam int                EXP_BIAS = 127;
  localparam logic [WORD_W-1:0] QNAN     = 32'h7FC00000;

  // Packed result plus its classification, stored together in one FIFO slot
  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              nan;
    logic              inf;
    logic              zero;
  } fdiv_entry_t;

  // Classify a packed binary32 word; subnormals are neither zero nor special
  function automatic fdiv_entry_t classify(input logic [WORD_W-1:0] w);
    fdiv_entry_t e;
    e.word = w;
    e.nan  = (w[30:23] == EXP_MAX) && (w[22:0] != '0);
    e.inf  = (w[30:23] == EXP_MAX) && (w[22:0] == '0);
    e.zero = (w[30:0] == '0);
    return e;
  endfunction

endpackage

// File: rtl/fdiv_pack.sv
// rtl/fdiv_pack.sv - canonicalises and packs one divider result into a classified binary32 entry
module fdiv_pack
  import fdiv_pkg::*;
#(
  parameter bit CANON_NAN = 1'b1,
  parameter bit FTZ       = 1'b1
) (
  input  logic              res_sign,
  input  logic [EXP_W-1:0]  res_exp,
  input  logic [FRAC_W-1:0] res_frac,
  input  logic              res_error,
  input  logic              res_overflow,
  output fdiv_entry_t       entry
);

  logic              is_nan;
  logic [WORD_W-1:0] word;

  // Pack rules in priority order: NaN, infinity, flushed zero, plain value
  always_comb begin
    word   = {res_sign, res_exp, res_frac};
    is_nan = res_error || ((res_exp == EXP_MAX) && (res_frac != '0));
    if (is_nan) begin
      if (CANON_NAN) word = QNAN;
    end else if (res_overflow || (res_exp == EXP_MAX)) begin
      word = {res_sign, EXP_MAX, {FRAC_W{1'b0}}};
    end else if ((res_exp == '0) && FTZ) begin
      word = {res_sign, {(WORD_W-1){1'b0}}};
    end
    entry = classify(word);
  end

endmodule

// File: rtl/fdiv_out_stage.sv
// rtl/fdiv_out_stage.sv - divider output FIFO with binary32 packing; FDIV_STATUS_EN adds sticky status flags
module fdiv_out_stage
  import fdiv_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit CANON_NAN = 1'b1,
  parameter bit FTZ       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [23:0]       in_frac,
  input  logic              in_error,
  input  logic              in_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_nan,
  output logic              out_inf,
`ifdef FDIV_STATUS_EN
  output logic              out_zero,
  input  logic              status_clr,
  output logic              sts_invalid,
  output logic              sts_inf,
  output logic              sts_zero
`else
  output logic              out_zero
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fdiv_entry_t   mem [DEPTH];
  fdiv_entry_t   wr_entry;
  fdiv_entry_t   head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;
  logic          unused_frac_msb;

  assign unused_frac_msb = in_frac[23];

  fdiv_pack #(
    .CANON_NAN (CANON_NAN),
    .FTZ       (FTZ)
  ) u_pack (
    .res_sign     (in_sign),
    .res_exp      (in_exp),
    .res_frac     (in_frac[22:0]),
    .res_error    (in_error),
    .res_overflow (in_overflow),
    .entry        (wr_entry)
  );

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign do_wr     = in_valid && in_ready;
  assign do_rd     = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  assign out_data = out_valid ? head.word : '0;
  assign out_nan  = out_valid && head.nan;
  assign out_inf  = out_valid && head.inf;
  assign out_zero = out_valid && head.zero;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are left stale on reset since count masks them
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[wr_ptr] <= wr_entry;
  end

`ifdef FDIV_STATUS_EN
  // Sticky class flags; a set on an accepted write overrides a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sts_invalid <= 1'b0;
      sts_inf     <= 1'b0;
      sts_zero    <= 1'b0;
    end else begin
      sts_invalid <= (sts_invalid && !status_clr) || (do_wr && wr_entry.nan);
      sts_inf     <= (sts_inf && !status_clr)     || (do_wr && wr_entry.inf);
      sts_zero    <= (sts_zero && !status_clr)    || (do_wr && wr_entry.zero);
    end
  end
`endif

endmodule
